// File: rtl/i2s_pkg.sv
// Shared I2S definitions: slot length, framing FSM states and lrclk polarity.
// Used by both the transmitter and the upstream receiver.
package i2s_pkg;

  localparam int unsigned SLOTBITS_DEF = 32;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic LRCLK_LEFT  = 1'b0;
  localparam logic LRCLK_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_piso.sv
// Parallel-load / serial-out shifter, MSB first, zero-filled from the right.
// Load takes priority over shift.
module i2s_piso #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_dout
);

  logic [WIDTH-1:0] r_sreg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_din;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign o_dout = r_sreg[WIDTH-1];

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: serialises a stereo pair MSB-first against an external lrclk,
// checks slot framing and resynchronises on the next falling lrclk edge after a fault.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned BITSIZE  = 16,
  parameter int unsigned SLOTBITS = SLOTBITS_DEF
) (
  input  logic               bclk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               lrclk,
  input  logic [BITSIZE-1:0] left_in,
  input  logic [BITSIZE-1:0] right_in,
  output logic               sdata,
  output logic               sample_req,
  output logic               frame_err
);

  localparam int unsigned   CW       = (SLOTBITS > 1) ? $clog2(SLOTBITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOTBITS - 1);
  localparam int unsigned   PAD      = SLOTBITS - BITSIZE;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                r_lrclk_q;
  logic                r_hist_vld;
  logic [BITSIZE-1:0]  r_right_hold;
  logic                r_sdata;
  logic                r_req;
  logic                r_err;

  logic                w_fall;
  logic                w_rise;
  logic                w_edge;
  logic                w_at_end;
  logic                w_load;
  logic                w_load_left;
  logic                w_shift;
  logic                w_latch;
  logic                w_sdata_nxt;
  logic                w_req_nxt;
  logic                w_err_nxt;
  logic                w_piso_out;
  logic [SLOTBITS-1:0] w_piso_din;

  // r_lrclk_q resets high, but the first sample after reset has no real history,
  // so edges are only qualified once r_hist_vld is set.
  assign w_fall   = r_hist_vld && (lrclk == LRCLK_LEFT)  && (r_lrclk_q == LRCLK_RIGHT);
  assign w_rise   = r_hist_vld && (lrclk == LRCLK_RIGHT) && (r_lrclk_q == LRCLK_LEFT);
  assign w_edge   = w_fall || w_rise;
  assign w_at_end = (r_cnt == CNT_LAST);

  assign w_piso_din = w_load_left ? (SLOTBITS'(left_in) << PAD)
                                  : (SLOTBITS'(r_right_hold) << PAD);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_load_left = 1'b0;
    w_shift     = 1'b0;
    w_latch     = 1'b0;
    w_sdata_nxt = 1'b0;
    w_req_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_SYNC;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_SYNC: begin
          w_cnt_nxt = '0;
          if (w_fall) begin
            w_load      = 1'b1;
            w_load_left = 1'b1;
            w_latch     = 1'b1;
            w_req_nxt   = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          w_sdata_nxt = w_piso_out;
          if (w_at_end && w_edge) begin
            // Falling edge starts a new frame: capture both channels together.
            w_load      = 1'b1;
            w_load_left = w_fall;
            w_latch     = w_fall;
            w_req_nxt   = w_fall;
            w_cnt_nxt   = '0;
          end else if (w_at_end || w_edge) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_SYNC;
            w_cnt_nxt   = '0;
          end else begin
            w_shift   = 1'b1;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_SYNC;
      r_cnt        <= '0;
      r_lrclk_q    <= LRCLK_RIGHT;
      r_hist_vld   <= 1'b0;
      r_right_hold <= '0;
      r_sdata      <= 1'b0;
      r_req        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lrclk_q  <= lrclk;
      r_hist_vld <= 1'b1;
      if (w_latch) begin
        r_right_hold <= right_in;
      end
      r_sdata <= w_sdata_nxt;
      r_req   <= w_req_nxt;
      r_err   <= w_err_nxt;
    end
  end

  i2s_piso #(
    .WIDTH(SLOTBITS)
  ) u_piso (
    .i_clk   (bclk),
    .i_rst_n (resetn),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_din   (w_piso_din),
    .o_dout  (w_piso_out)
  );

  assign sdata      = r_sdata;
  assign sample_req = r_req;
  assign frame_err  = r_err;

endmodule
